ula_acc_ctrl: RTL and testbench

ULA_ACC_CTRL -- requirements
Module: ula_acc_ctrl

---
 rtl/ula_acc_ctrl.sv | 104 ++++++++++
 tb/tb_ula_acc_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_acc_ctrl.sv
// Accumulator controller for an external combinational ALU: accepts one command,
// runs it through the ALU for one cycle, then presents the result until consumed.
module ula_acc_ctrl #(
    parameter int BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_cmd,
    input  logic signed [BITS-1:0] in_data,
    output logic signed [BITS-1:0] alu_a,
    output logic signed [BITS-1:0] alu_b,
    output logic [1:0]             alu_f,
    input  logic signed [BITS-1:0] alu_saida,
    input  logic                   alu_flag_o,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [BITS-1:0] acc,
    output logic                   ovf,
    output logic                   ovf_sticky,
    output logic                   zero,
    output logic                   neg,
    output logic                   err,
    output logic [7:0]             op_count,
    output logic [1:0]             dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]             state;
    logic [2:0]             cmd_q;
    logic signed [BITS-1:0] data_q;

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // valid never depends on ready, and once out_valid rises it holds with stable data
    // until out_ready is seen.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);
    assign dbg_state = state;

    assign alu_a = acc;
    assign alu_b = data_q;
    assign alu_f = (state == EXEC) ? cmd_q[1:0] : 2'b00;

    assign zero = (acc == '0);
    assign neg  = acc[BITS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_q      <= '0;
            data_q     <= '0;
            acc        <= '0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
            err        <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cmd_q  <= in_cmd;
                        data_q <= in_data;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    state    <= RESP;
                    op_count <= op_count + 8'd1;
                    if (!cmd_q[2]) begin
                        acc        <= alu_saida;
                        ovf        <= alu_flag_o;
                        ovf_sticky <= ovf_sticky | alu_flag_o;
                        err        <= 1'b0;
                    end else begin
                        // 100 LOAD, 101 CLEAR, 11x illegal (state kept, err raised)
                        case (cmd_q[1:0])
                            2'b00: begin
                                acc <= data_q;
                                ovf <= 1'b0;
                                err <= 1'b0;
                            end
                            2'b01: begin
                                acc        <= '0;
                                ovf        <= 1'b0;
                                ovf_sticky <= 1'b0;
                                err        <= 1'b0;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                RESP: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_acc_ctrl.sv
// Directed bench for ula_acc_ctrl with a behavioural 8-bit ALU attached to its ALU port.
module tb_ula_acc_ctrl;

    localparam int BITS = 8;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             in_cmd;
    logic signed [BITS-1:0] in_data;
    logic signed [BITS-1:0] alu_a;
    logic signed [BITS-1:0] alu_b;
    logic [1:0]             alu_f;
    logic signed [BITS-1:0] alu_saida;
    logic                   alu_flag_o;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [BITS-1:0] acc;
    logic                   ovf;
    logic                   ovf_sticky;
    logic                   zero;
    logic                   neg;
    logic                   err;
    logic [7:0]             op_count;
    logic [1:0]             dbg_state;

    int checks;
    int failures;

    ula_acc_ctrl #(.BITS(BITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_data    (in_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_saida  (alu_saida),
        .alu_flag_o (alu_flag_o),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc        (acc),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .zero       (zero),
        .neg        (neg),
        .err        (err),
        .op_count   (op_count),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external ALU: AND, OR, ADD, SUB with signed overflow flag
    always_comb begin
        alu_saida  = '0;
        alu_flag_o = 1'b0;
        case (alu_f)
            2'b00: alu_saida = alu_a & alu_b;
            2'b01: alu_saida = alu_a | alu_b;
            2'b10: begin
                alu_saida  = alu_a + alu_b;
                alu_flag_o = (alu_a[7] == alu_b[7]) && (alu_saida[7] != alu_a[7]);
            end
            default: begin
                alu_saida  = alu_a - alu_b;
                alu_flag_o = (alu_a[7] != alu_b[7]) && (alu_saida[7] != alu_a[7]);
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: issue one command, check latency and hold in RESP for hold cycles
    task automatic run_cmd(input logic [2:0] cmd, input logic [7:0] data, input int hold);
        int waited;
        waited = 0;
        while (!in_ready && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_data  = data;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'hA5;
        check("exec_no_valid", {31'd0, out_valid}, 32'd0);
        check("exec_state", {30'd0, dbg_state}, 32'd1);
        @(posedge clk); #1;
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                in_cmd   = 3'b101;
                in_data  = 8'h77;
            end
            if (i == 2) in_valid = 1'b0;
            @(posedge clk); #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_not_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("back_idle_valid", {31'd0, out_valid}, 32'd0);
        check("back_idle_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_cmd    = 3'd0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_neg", {31'd0, neg}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_acc", {24'd0, acc}, 32'd0);
        check("rst_cnt", {24'd0, op_count}, 32'd0);
        check("rst_alu_b", {24'd0, alu_b}, 32'd0);
        check("rst_alu_f", {30'd0, alu_f}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);

        // LOAD 100, ADD 50 -> -106 with overflow
        run_cmd(3'b100, 8'd100, 0);
        check("load100_acc", {24'd0, acc}, 32'h64);
        run_cmd(3'b010, 8'd50, 0);
        check("add_acc", {24'd0, acc}, 32'h96);
        check("add_ovf", {31'd0, ovf}, 32'd1);
        check("add_sticky", {31'd0, ovf_sticky}, 32'd1);
        check("add_neg", {31'd0, neg}, 32'd1);
        check("add_cnt", {24'd0, op_count}, 32'd2);

        // LOAD -128, SUB 1 -> 127 with overflow, then CLEAR
        run_cmd(3'b100, 8'h80, 0);
        check("load80_ovf", {31'd0, ovf}, 32'd0);
        check("load80_sticky", {31'd0, ovf_sticky}, 32'd1);
        run_cmd(3'b011, 8'd1, 0);
        check("sub_acc", {24'd0, acc}, 32'h7F);
        check("sub_ovf", {31'd0, ovf}, 32'd1);
        run_cmd(3'b101, 8'h33, 0);
        check("clr_acc", {24'd0, acc}, 32'd0);
        check("clr_zero", {31'd0, zero}, 32'd1);
        check("clr_ovf", {31'd0, ovf}, 32'd0);
        check("clr_sticky", {31'd0, ovf_sticky}, 32'd0);
        check("clr_cnt", {24'd0, op_count}, 32'd5);

        // set sticky, then logic ops must leave it alone
        run_cmd(3'b100, 8'h7F, 0);
        run_cmd(3'b010, 8'h01, 0);
        check("add7f_acc", {24'd0, acc}, 32'h80);
        check("add7f_sticky", {31'd0, ovf_sticky}, 32'd1);
        run_cmd(3'b100, 8'hF0, 0);
        run_cmd(3'b000, 8'h3C, 0);
        check("and_acc", {24'd0, acc}, 32'h30);
        check("and_ovf", {31'd0, ovf}, 32'd0);
        run_cmd(3'b001, 8'h0F, 0);
        check("or_acc", {24'd0, acc}, 32'h3F);
        check("or_sticky", {31'd0, ovf_sticky}, 32'd1);
        check("or_cnt", {24'd0, op_count}, 32'd10);

        // backpressure: hold RESP for 5 cycles with a stray in_valid pulse
        run_cmd(3'b100, 8'h11, 5);
        check("hold_acc", {24'd0, acc}, 32'h11);
        check("hold_cnt", {24'd0, op_count}, 32'd11);
        check("hold_sticky", {31'd0, ovf_sticky}, 32'd1);

        // illegal command keeps state and raises err
        run_cmd(3'b100, 8'd5, 0);
        run_cmd(3'b110, 8'd9, 0);
        check("ill_err", {31'd0, err}, 32'd1);
        check("ill_acc", {24'd0, acc}, 32'd5);
        check("ill_cnt", {24'd0, op_count}, 32'd13);
        run_cmd(3'b010, 8'd1, 0);
        check("post_ill_err", {31'd0, err}, 32'd0);
        check("post_ill_acc", {24'd0, acc}, 32'd6);

        // reset during EXEC of an ADD
        run_cmd(3'b100, 8'd3, 0);
        in_valid = 1'b1;
        in_cmd   = 3'b010;
        in_data  = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_exec", {30'd0, dbg_state}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("exec_rst_state", {30'd0, dbg_state}, 32'd0);
        check("exec_rst_acc", {24'd0, acc}, 32'd0);
        check("exec_rst_valid", {31'd0, out_valid}, 32'd0);
        check("exec_rst_cnt", {24'd0, op_count}, 32'd0);
        @(posedge clk); #1;
        check("exec_rst_still", {24'd0, acc}, 32'd0);

        // 256 commands wrap the counter
        for (int i = 0; i < 256; i++) begin
            run_cmd(3'b100, i[7:0], 0);
            if (i == 254) check("cnt_255", {24'd0, op_count}, 32'd255);
        end
        check("cnt_wrap", {24'd0, op_count}, 32'd0);
        check("wrap_acc", {24'd0, acc}, 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
